// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad number-entry block: key codes,
// scanner states, column reset pattern and key-map helpers.
package keypad_pkg;

   localparam logic [3:0] KEY_BACK  = 4'hA;
   localparam logic [3:0] KEY_CLR   = 4'hE;
   localparam logic [3:0] KEY_ENT   = 4'hF;
   localparam logic [3:0] COL_RESET = 4'b1110;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      ACCEPT   = 2'd2,
      HELD     = 2'd3
   } scan_state_e;

   // Physical keypad layout: row-major position -> key code
   function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
      logic [3:0] k;
      k = 4'h0;
      case ({r, c})
         4'd0:  k = 4'h1;
         4'd1:  k = 4'h2;
         4'd2:  k = 4'h3;
         4'd3:  k = 4'hA;
         4'd4:  k = 4'h4;
         4'd5:  k = 4'h5;
         4'd6:  k = 4'h6;
         4'd7:  k = 4'hB;
         4'd8:  k = 4'h7;
         4'd9:  k = 4'h8;
         4'd10: k = 4'h9;
         4'd11: k = 4'hC;
         4'd12: k = 4'hE;
         4'd13: k = 4'h0;
         4'd14: k = 4'hF;
         default: k = 4'hD;
      endcase
      return k;
   endfunction

   // Index of the column currently driven low (one-hot-low input)
   function automatic logic [1:0] col_index(input logic [3:0] col_n);
      logic [1:0] idx;
      idx = 2'd0;
      if (!col_n[1])      idx = 2'd1;
      else if (!col_n[2]) idx = 2'd2;
      else if (!col_n[3]) idx = 2'd3;
      return idx;
   endfunction

endpackage

// File: rtl/keypad_accum.sv
// Operand accumulator: turns accepted key codes into a decimal number,
// digit count and an enter pulse. Updates on the same edge the strobe
// register rises, so outputs line up with key_strobe.
module keypad_accum
   import keypad_pkg::*;
#(
   parameter int DIGITS = 4,
   parameter int NUM_W  = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       key_code,
   input  logic             key_strobe,
   output logic [NUM_W-1:0] number,
   output logic [2:0]       digit_cnt,
   output logic             num_valid
);

   localparam logic [2:0] MAX_DIG = 3'(DIGITS);

   logic [NUM_W-1:0] number_q, number_d;
   logic [2:0]       cnt_q, cnt_d;
   logic             done_q, done_d;
   logic             valid_q, valid_d;

   // n*10 + d built from shifts at NUM_W+4 bits, then truncated
   function automatic logic [NUM_W-1:0] times10_plus(input logic [NUM_W-1:0] n,
                                                     input logic [3:0] d);
      logic [NUM_W+3:0] w;
      w = ({4'b0, n} << 3) + ({4'b0, n} << 1) + {{NUM_W{1'b0}}, d};
      return w[NUM_W-1:0];
   endfunction

   // Edit action for the accepted key
   always_comb begin
      number_d = number_q;
      cnt_d    = cnt_q;
      done_d   = done_q;
      valid_d  = 1'b0;
      if (key_strobe) begin
         case (key_code)
            KEY_BACK: begin
               if (cnt_q != 3'd0) begin
                  number_d = number_q / NUM_W'(10);
                  cnt_d    = cnt_q - 3'd1;
               end
               done_d = 1'b0;
            end
            KEY_CLR: begin
               number_d = '0;
               cnt_d    = 3'd0;
               done_d   = 1'b0;
            end
            KEY_ENT: begin
               valid_d = 1'b1;
               done_d  = 1'b1;
            end
            default: begin
               if (key_code <= 4'd9) begin
                  if (done_q) begin
                     number_d = NUM_W'(key_code);
                     cnt_d    = 3'd1;
                     done_d   = 1'b0;
                  end else if (cnt_q < MAX_DIG) begin
                     number_d = times10_plus(number_q, key_code);
                     cnt_d    = cnt_q + 3'd1;
                  end
               end
            end
         endcase
      end
   end

   // Operand state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         number_q <= '0;
         cnt_q    <= 3'd0;
         done_q   <= 1'b0;
         valid_q  <= 1'b0;
      end else begin
         number_q <= number_d;
         cnt_q    <= cnt_d;
         done_q   <= done_d;
         valid_q  <= valid_d;
      end
   end

   assign number    = number_q;
   assign digit_cnt = cnt_q;
   assign num_valid = valid_q;

endmodule

// File: rtl/keypad_number_entry.sv
// 4x4 keypad scanner with debounce feeding a decimal operand accumulator.
// Columns are driven low one slot at a time; rows are sampled on the last
// cycle of each slot through a 2-flop synchronizer.
module keypad_number_entry
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV       = 3000,
   parameter int DEBOUNCE_SCANS = 4,
   parameter int DIGITS         = 4,
   parameter int NUM_W          = 14
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       row,
   output logic [3:0]       col,
   output logic [NUM_W-1:0] number,
   output logic [2:0]       digit_cnt,
   output logic [3:0]       key_code,
   output logic             key_strobe,
   output logic             num_valid
);

   localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int CNT_W  = $clog2(DEBOUNCE_SCANS + 1);
   localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SCAN_DIV - 1);
   localparam logic [CNT_W-1:0]  CNT_DONE  = CNT_W'(DEBOUNCE_SCANS);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   logic [3:0]        row_meta_q, row_sync_q;
   logic [SLOT_W-1:0] slot_q;
   scan_state_e       state_q, state_d;
   logic [3:0]        col_q, col_d;
   logic [3:0]        cand_q, cand_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [CNT_W-1:0]  cnt_inc;
   logic [3:0]        key_code_q, key_code_d;
   logic              key_strobe_q, key_strobe_d;
   logic              sample;
   logic              key_any;
   logic [1:0]        row_idx;
   logic [3:0]        key_now;

   // Bring the asynchronous row lines into the clock domain
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_meta_q <= 4'hF;
         row_sync_q <= 4'hF;
      end else begin
         row_meta_q <= row;
         row_sync_q <= row_meta_q;
      end
   end

   // Slot timer; the last cycle of each slot is the row sample point
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                   slot_q <= '0;
      else if (slot_q == SLOT_LAST) slot_q <= '0;
      else                       slot_q <= slot_q + 1'b1;
   end

   assign sample  = (slot_q == SLOT_LAST);
   assign key_any = ~&row_sync_q;
   assign cnt_inc = cnt_q + 1'b1;
   assign key_now = key_lookup(row_idx, col_index(col_q));

   // Lowest active row wins when several rows are low
   always_comb begin
      row_idx = 2'd3;
      if (!row_sync_q[0])      row_idx = 2'd0;
      else if (!row_sync_q[1]) row_idx = 2'd1;
      else if (!row_sync_q[2]) row_idx = 2'd2;
   end

   // Scanner FSM next state: rotate, debounce press, strobe, await release
   always_comb begin
      state_d      = state_q;
      col_d        = col_q;
      cand_d       = cand_q;
      cnt_d        = cnt_q;
      key_code_d   = key_code_q;
      key_strobe_d = 1'b0;
      case (state_q)
         SCAN: begin
            if (sample) begin
               if (key_any) begin
                  cand_d = key_now;
                  cnt_d  = CNT_ONE;
                  if (CNT_ONE >= CNT_DONE) begin
                     state_d      = ACCEPT;
                     key_strobe_d = 1'b1;
                     key_code_d   = key_now;
                  end else begin
                     state_d = DEBOUNCE;
                  end
               end else begin
                  col_d = {col_q[2:0], col_q[3]};
               end
            end
         end
         DEBOUNCE: begin
            if (sample) begin
               if (key_any && (key_now == cand_q)) begin
                  cnt_d = cnt_inc;
                  if (cnt_inc >= CNT_DONE) begin
                     state_d      = ACCEPT;
                     key_strobe_d = 1'b1;
                     key_code_d   = cand_q;
                  end
               end else begin
                  state_d = SCAN;
               end
            end
         end
         ACCEPT: begin
            state_d = HELD;
            cnt_d   = '0;
         end
         HELD: begin
            if (sample) begin
               if (!key_any) begin
                  if (cnt_inc >= CNT_DONE) begin
                     state_d = SCAN;
                     cnt_d   = '0;
                  end else begin
                     cnt_d = cnt_inc;
                  end
               end else begin
                  cnt_d = '0;
               end
            end
         end
         default: state_d = SCAN;
      endcase
   end

   // Scanner state registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= SCAN;
         col_q        <= COL_RESET;
         cand_q       <= 4'h0;
         cnt_q        <= '0;
         key_code_q   <= 4'h0;
         key_strobe_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         col_q        <= col_d;
         cand_q       <= cand_d;
         cnt_q        <= cnt_d;
         key_code_q   <= key_code_d;
         key_strobe_q <= key_strobe_d;
      end
   end

   // Fed with next-state values so the operand changes with the strobe
   keypad_accum #(
      .DIGITS (DIGITS),
      .NUM_W  (NUM_W)
   ) u_accum (
      .clk        (clk),
      .rst        (rst),
      .key_code   (key_code_d),
      .key_strobe (key_strobe_d),
      .number     (number),
      .digit_cnt  (digit_cnt),
      .num_valid  (num_valid)
   );

   assign col        = col_q;
   assign key_code   = key_code_q;
   assign key_strobe = key_strobe_q;

endmodule

// File: tb/tb_keypad_number_entry.sv
// Bench for keypad_number_entry: a keypad model drives rows from the
// scanned columns; accepted keys are checked against a digit-list model.
module tb_keypad_number_entry;

   localparam int SCAN_DIV = 4;
   localparam int DEB      = 2;
   localparam int DIGITS   = 4;
   localparam int NUM_W    = 14;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [3:0]       row;
   logic [3:0]       col;
   logic [NUM_W-1:0] number;
   logic [2:0]       digit_cnt;
   logic [3:0]       key_code;
   logic             key_strobe;
   logic             num_valid;

   logic [15:0] key_down = '0;   // physical keys, index = row*4 + col

   int n_checks = 0;
   int n_errors = 0;
   int n_strobe = 0;
   int n_valid  = 0;

   int m_digits[$];
   bit m_done  = 1'b0;
   bit m_valid = 1'b0;

   logic [3:0] keymap [16] = '{4'h1, 4'h2, 4'h3, 4'hA,
                               4'h4, 4'h5, 4'h6, 4'hB,
                               4'h7, 4'h8, 4'h9, 4'hC,
                               4'hE, 4'h0, 4'hF, 4'hD};
   logic [3:0] colseq [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

   keypad_number_entry #(
      .SCAN_DIV       (SCAN_DIV),
      .DEBOUNCE_SCANS (DEB),
      .DIGITS         (DIGITS),
      .NUM_W          (NUM_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .row        (row),
      .col        (col),
      .number     (number),
      .digit_cnt  (digit_cnt),
      .key_code   (key_code),
      .key_strobe (key_strobe),
      .num_valid  (num_valid)
   );

   always #5 clk = ~clk;

   // Matrix: a row reads low when a pressed key sits in the driven column
   always_comb begin
      row = 4'hF;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (!col[c] && key_down[r*4+c]) row[r] = 1'b0;
   end

   always @(negedge clk) begin
      if (key_strobe === 1'b1) n_strobe++;
      if (num_valid === 1'b1)  n_valid++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int m_value();
      int v = 0;
      foreach (m_digits[i]) v = v * 10 + m_digits[i];
      return v;
   endfunction

   function automatic void model_reset();
      m_digits.delete();
      m_done  = 1'b0;
      m_valid = 1'b0;
   endfunction

   // Operand modelled as the list of entered digits
   function automatic void model_apply(input logic [3:0] code);
      m_valid = 1'b0;
      if (code <= 4'd9) begin
         if (m_done) begin
            m_digits.delete();
            m_digits.push_back(int'(code));
            m_done = 1'b0;
         end else if (m_digits.size() < DIGITS) begin
            m_digits.push_back(int'(code));
         end
      end else if (code == 4'hA) begin
         if (m_digits.size() > 0) void'(m_digits.pop_back());
         m_done = 1'b0;
      end else if (code == 4'hE) begin
         m_digits.delete();
         m_done = 1'b0;
      end else if (code == 4'hF) begin
         m_valid = 1'b1;
         m_done  = 1'b1;
      end
   endfunction

   function automatic int pos_of(input logic [3:0] code);
      int p = 0;
      for (int i = 0; i < 16; i++) if (keymap[i] == code) p = i;
      return p;
   endfunction

   task automatic expect_strobe(input logic [3:0] code, input string tag);
      bit seen = 1'b0;
      model_apply(code);
      for (int i = 0; i < 400 && !seen; i++) begin
         @(negedge clk);
         if (key_strobe === 1'b1) seen = 1'b1;
      end
      check({tag, "_seen"}, 32'(seen), 32'd1);
      if (seen) begin
         check({tag, "_code"},  32'(key_code),  32'(code));
         check({tag, "_num"},   32'(number),    32'(m_value()));
         check({tag, "_cnt"},   32'(digit_cnt), 32'(m_digits.size()));
         check({tag, "_valid"}, 32'(num_valid), 32'(m_valid));
      end
   endtask

   task automatic press_key(input logic [3:0] code, input string tag);
      int s0 = n_strobe;
      int v0 = n_valid;
      int p  = pos_of(code);
      key_down[p] = 1'b1;
      expect_strobe(code, tag);
      key_down[p] = 1'b0;
      repeat (40) @(negedge clk);
      check({tag, "_once"},   32'(n_strobe - s0), 32'd1);
      check({tag, "_vcount"}, 32'(n_valid - v0),  32'(m_valid));
   endtask

   initial begin
      int s0;
      logic [3:0] rk;

      // Reset state and free-running column scan
      rst = 1'b1;
      repeat (3) @(negedge clk);
      check("rst_col",    32'(col),        32'(4'b1110));
      check("rst_num",    32'(number),     32'd0);
      check("rst_cnt",    32'(digit_cnt),  32'd0);
      check("rst_code",   32'(key_code),   32'd0);
      check("rst_strobe", 32'(key_strobe), 32'd0);
      check("rst_valid",  32'(num_valid),  32'd0);
      rst = 1'b0;
      for (int n = 1; n <= 16; n++) begin
         @(negedge clk);
         check("col_seq", 32'(col), 32'(colseq[(n/4)%4]));
      end
      check("idle_strobes", 32'(n_strobe), 32'd0);
      check("idle_num",     32'(number),   32'd0);

      // Five digits, the fifth is ignored
      press_key(4'h1, "t2_k1");
      press_key(4'h2, "t2_k2");
      press_key(4'h3, "t2_k3");
      press_key(4'h4, "t2_k4");
      press_key(4'h5, "t2_k5");
      check("t2_num", 32'(number),    32'd1234);
      check("t2_cnt", 32'(digit_cnt), 32'd4);

      // Enter then a new digit restarts the operand
      press_key(4'hE, "t3_clr");
      press_key(4'h4, "t3_k4");
      press_key(4'h2, "t3_k2");
      press_key(4'hF, "t3_ent");
      press_key(4'h7, "t3_k7");
      check("t3_num", 32'(number),    32'd7);
      check("t3_cnt", 32'(digit_cnt), 32'd1);

      // Backspace and clear
      press_key(4'hE, "t4_clr0");
      press_key(4'h9, "t4_k9");
      press_key(4'h0, "t4_k0");
      press_key(4'h5, "t4_k5");
      press_key(4'hA, "t4_back");
      check("t4_back_num", 32'(number),    32'd90);
      check("t4_back_cnt", 32'(digit_cnt), 32'd2);
      press_key(4'hE, "t4_clr");
      check("t4_clr_num", 32'(number),    32'd0);
      check("t4_clr_cnt", 32'(digit_cnt), 32'd0);

      // Bouncing press and bouncing release of key '1'
      s0 = n_strobe;
      for (int i = 0; i < 6; i++) begin
         key_down[0] = (i % 2 == 0);
         repeat (SCAN_DIV) @(negedge clk);
      end
      check("t5_bounce_quiet", 32'(n_strobe - s0), 32'd0);
      key_down[0] = 1'b1;
      expect_strobe(4'h1, "t5_press");
      for (int i = 0; i < 6; i++) begin
         key_down[0] = (i % 2 == 1);
         repeat (SCAN_DIV) @(negedge clk);
      end
      key_down[0] = 1'b0;
      repeat (40) @(negedge clk);
      check("t5_one_strobe", 32'(n_strobe - s0), 32'd1);

      // Random key sequence against the model
      for (int i = 0; i < 40; i++) begin
         rk = 4'($urandom_range(15, 0));
         press_key(rk, "rand");
      end

      // Two rows low in column 0 from reset: lowest row wins, exact latency
      rst = 1'b1;
      model_reset();
      key_down[4]  = 1'b1;
      key_down[12] = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      model_apply(4'h4);
      for (int n = 1; n <= 8; n++) begin
         @(negedge clk);
         check("t6_latency", 32'(key_strobe), 32'(n == 8));
         if (n == 8) begin
            check("t6_code", 32'(key_code),  32'h4);
            check("t6_num",  32'(number),    32'(m_value()));
            check("t6_cnt",  32'(digit_cnt), 32'(m_digits.size()));
         end
      end
      key_down = '0;
      repeat (40) @(negedge clk);

      // Reset in the middle of debounce abandons the key
      rst = 1'b1;
      model_reset();
      key_down[4]  = 1'b1;
      key_down[12] = 1'b1;
      repeat (2) @(negedge clk);
      s0 = n_strobe;
      rst = 1'b0;
      repeat (5) @(negedge clk);
      rst = 1'b1;
      #1;
      check("t6_rst_col",    32'(col),        32'(4'b1110));
      check("t6_rst_strobe", 32'(key_strobe), 32'd0);
      check("t6_rst_num",    32'(number),     32'd0);
      key_down = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      check("t6_no_strobe", 32'(n_strobe - s0), 32'd0);
      check("t6_code_rst",  32'(key_code),      32'd0);
      check("t6_cnt_rst",   32'(digit_cnt),     32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
